// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
// Owns HI/LO and runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle
// operations. The result is computed at issue and held in temporaries
// until the busy period expires, then committed to HI/LO.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset_n    asynchronous active-low reset
//   Start      E-stage instruction is an MD op (one-cycle request)
//   MD_Op      0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
//   Data_A     forwarded rs value
//   Data_B     forwarded rt value
//   Busy       multi-cycle operation in flight
//   MD_Hazard  Busy, or a multi-cycle op being requested this cycle
//   HI, LO     architectural HI/LO registers
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [2:0]  MD_Op,
  input  logic [31:0] Data_A,
  input  logic [31:0] Data_B,
  output logic        Busy,
  output logic        MD_Hazard,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] temp_hi_q, temp_hi_d;
  logic [31:0] temp_lo_q, temp_lo_d;
  logic        temp_we_q, temp_we_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_multi_op;
  logic [63:0] prod_s, prod_u;
  logic        div_by_zero;
  logic [31:0] divisor_u, quot_u, rem_u;
  logic [31:0] abs_a, abs_b, divisor_s, quot_mag, rem_mag, quot_s, rem_s;

  assign is_multi_op = (MD_Op >= OpMult) && (MD_Op <= OpDivu);

  // Operands are sign/zero-extended to 64 bits so the low 64 bits of the
  // product are exact in both cases.
  assign prod_s = {{32{Data_A[31]}}, Data_A} * {{32{Data_B[31]}}, Data_B};
  assign prod_u = {32'd0, Data_A} * {32'd0, Data_B};

  // Divisor forced to 1 on divide-by-zero only to keep the dividers defined;
  // the result is never committed in that case.
  assign div_by_zero = (Data_B == 32'd0);
  assign divisor_u   = div_by_zero ? 32'd1 : Data_B;
  assign quot_u      = Data_A / divisor_u;
  assign rem_u       = Data_A % divisor_u;

  // Signed divide on magnitudes: 0x80000000 has magnitude 0x80000000 as an
  // unsigned value, so the -2^31 / -1 case falls out with LO=0x80000000, HI=0.
  assign abs_a     = Data_A[31] ? (32'd0 - Data_A) : Data_A;
  assign abs_b     = Data_B[31] ? (32'd0 - Data_B) : Data_B;
  assign divisor_s = div_by_zero ? 32'd1 : abs_b;
  assign quot_mag  = abs_a / divisor_s;
  assign rem_mag   = abs_a % divisor_s;
  assign quot_s    = (Data_A[31] ^ Data_B[31]) ? (32'd0 - quot_mag) : quot_mag;
  assign rem_s     = Data_A[31] ? (32'd0 - rem_mag) : rem_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    temp_we_d = temp_we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          case (MD_Op)
            OpMult: begin
              {temp_hi_d, temp_lo_d} = prod_s;
              temp_we_d = 1'b1;
              cnt_d     = 4'(MULT_CYCLES);
              state_d   = StRun;
            end
            OpMultu: begin
              {temp_hi_d, temp_lo_d} = prod_u;
              temp_we_d = 1'b1;
              cnt_d     = 4'(MULT_CYCLES);
              state_d   = StRun;
            end
            OpDiv: begin
              temp_hi_d = rem_s;
              temp_lo_d = quot_s;
              temp_we_d = !div_by_zero;
              cnt_d     = 4'(DIV_CYCLES);
              state_d   = StRun;
            end
            OpDivu: begin
              temp_hi_d = rem_u;
              temp_lo_d = quot_u;
              temp_we_d = !div_by_zero;
              cnt_d     = 4'(DIV_CYCLES);
              state_d   = StRun;
            end
            OpMthi:  hi_d = Data_A;
            OpMtlo:  lo_d = Data_A;
            default: ;
          endcase
        end
      end
      StRun: begin
        // Any Start while running is deliberately ignored.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (temp_we_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      temp_hi_q <= 32'd0;
      temp_lo_q <= 32'd0;
      temp_we_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      temp_we_q <= temp_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy      = (state_q == StRun);
  assign MD_Hazard = Busy | (Start & is_multi_op);
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule
